// File: rtl/assoc_kv_cam.sv
// Associative key/value table with a two-part key {key1, key2}.
// Each request scans every entry once, one per cycle, then answers with a single-cycle response.
module assoc_kv_cam #(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [31:0]              req_key1,
   input  logic [63:0]              req_key2,
   input  logic [DW-1:0]            req_wdata,
   output logic                     rsp_valid,
   output logic                     rsp_hit,
   output logic [DW-1:0]            rsp_rdata,
   output logic                     rsp_err,
   output logic [$clog2(DEPTH):0]   count
);

   // state | meaning
   // IDLE  | ready for a request
   // SCAN  | examining entry r_idx, one per cycle, 0..DEPTH-1
   // RESP  | response strobe; table write commits on the edge leaving this state
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic             r_write;
   logic [31:0]      r_key1;
   logic [63:0]      r_key2;
   logic [DW-1:0]    r_wdata;
   logic             r_found;
   logic [IW-1:0]    r_match_idx;
   logic             r_free_ok;
   logic [IW-1:0]    r_free_idx;
   logic [CW-1:0]    r_count;
   logic [DEPTH-1:0] r_vld;
   logic [31:0]      r_tkey1 [DEPTH];
   logic [63:0]      r_tkey2 [DEPTH];
   logic [DW-1:0]    r_tdata [DEPTH];

   logic             w_match;
   logic             w_hit;
   logic [IW-1:0]    w_hit_idx;
   logic             w_has_free;
   logic [IW-1:0]    w_free_idx;
   logic             w_last;
   logic             w_commit_upd;
   logic             w_commit_new;

   // Include the entry under examination so the final index counts on the last scan edge.
   assign w_match    = r_vld[r_idx] && (r_tkey1[r_idx] == r_key1) && (r_tkey2[r_idx] == r_key2);
   assign w_hit      = r_found | w_match;
   assign w_hit_idx  = r_found ? r_match_idx : r_idx;
   assign w_has_free = r_free_ok | ~r_vld[r_idx];
   assign w_free_idx = r_free_ok ? r_free_idx : r_idx;
   assign w_last     = (r_idx == IW'(DEPTH - 1));

   assign w_commit_upd = !reset && (r_state == RESP) && r_write && r_found;
   assign w_commit_new = !reset && (r_state == RESP) && r_write && !r_found && r_free_ok;

   assign req_ready = (r_state == IDLE) && !reset;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_write     <= 1'b0;
         r_key1      <= '0;
         r_key2      <= '0;
         r_wdata     <= '0;
         r_found     <= 1'b0;
         r_match_idx <= '0;
         r_free_ok   <= 1'b0;
         r_free_idx  <= '0;
         r_count     <= '0;
         r_vld       <= '0;
         rsp_valid   <= 1'b0;
         rsp_hit     <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_write   <= req_write;
                  r_key1    <= req_key1;
                  r_key2    <= req_key2;
                  r_wdata   <= req_wdata;
                  r_idx     <= '0;
                  r_found   <= 1'b0;
                  r_free_ok <= 1'b0;
                  r_state   <= SCAN;
               end
            end
            SCAN: begin
               r_found     <= w_hit;
               r_match_idx <= w_hit_idx;
               r_free_ok   <= w_has_free;
               r_free_idx  <= w_free_idx;
               if (w_last) begin
                  r_state   <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_hit   <= w_hit;
                  rsp_rdata <= (!r_write && w_hit) ? r_tdata[w_hit_idx] : '0;
                  rsp_err   <= r_write && !w_hit && (r_count == CW'(DEPTH));
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            RESP: begin
               if (w_commit_new) begin
                  r_vld[r_free_idx] <= 1'b1;
                  r_count           <= r_count + CW'(1);
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Key/data storage needs no reset; only the valid bits define occupancy.
   always_ff @(posedge clk) begin
      if (w_commit_upd) begin
         r_tdata[r_match_idx] <= r_wdata;
      end else if (w_commit_new) begin
         r_tkey1[r_free_idx] <= r_key1;
         r_tkey2[r_free_idx] <= r_key2;
         r_tdata[r_free_idx] <= r_wdata;
      end
   end

endmodule

// File: doc/assoc_kv_cam.md
ASSOC_KV_CAM -- requirements
Module: assoc_kv_cam

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of table entries (power of two, 2..64).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_write, input, 1, 1=write, 0=lookup.
REQ-008 SHALL have port req_key1, input, 32, outer key.
REQ-009 SHALL have port req_key2, input, 64, inner key.
REQ-010 SHALL have port req_wdata, input, DW, write data.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle response strobe; no backpressure.
REQ-012 SHALL have port rsp_hit, output, 1, the key pair was found in the table.
REQ-013 SHALL have port rsp_rdata, output, DW, lookup data; 0 on miss and on writes.
REQ-014 SHALL have port rsp_err, output, 1, write rejected because the table is full.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, number of valid entries.

Function
REQ-016 SHALL store up to DEPTH entries, each {valid, key1[31:0], key2[63:0], data[DW-1:0]}; an entry matches only when both key1 and key2 are equal.
REQ-017 SHALL implement states IDLE, SCAN, RESP.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1, and the key, data and op are captured at that edge.
REQ-019 SHALL move from IDLE to SCAN on acceptance, and examine exactly one entry per cycle, from index 0 to DEPTH-1.
REQ-020 SHALL always scan all DEPTH entries (no early exit), and record the first matching index and the lowest free index.
REQ-021 SHALL move from SCAN to RESP after index DEPTH-1 is examined, and assert rsp_valid for exactly one cycle in RESP, i.e. in the cycle DEPTH+1 cycles after the acceptance edge.
REQ-022 SHALL return from RESP to IDLE on the next edge; req_ready is 1 again in the cycle after rsp_valid.
REQ-023 Lookup, hit: rsp_hit=1, rsp_rdata=stored data.
REQ-024 Lookup, miss: rsp_hit=0, rsp_rdata=0.
REQ-025 Write, key present: overwrite the data in place on the RESP edge; rsp_hit=1; count unchanged.
REQ-026 Write, key absent, table not full: fill the lowest free index on the RESP edge; rsp_hit=0; count increments by 1.
REQ-027 Write, key absent, table full (count==DEPTH): leave the table unchanged; rsp_err=1; rsp_hit=0.
REQ-028 rsp_err SHALL be 0 on every lookup and on every accepted write.
REQ-029 rsp_hit, rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-030 SHALL provide no delete operation; count saturates at DEPTH.
REQ-031 SHALL ignore req_valid whenever req_ready is 0 (the requester holds its request).

Reset
REQ-032 While reset is 1: state=IDLE; all entry valid bits=0; count=0; rsp_valid=rsp_hit=rsp_err=0; rsp_rdata=0; req_ready=0.
REQ-033 Reset asserted during SCAN or RESP SHALL abort the operation: no response, no table update.
REQ-034 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Write (5,8)=8, then (5,9)=9, then look up (5,8) and (5,9) -> each write gives rsp_hit=0; lookups give hit=1 with rdata 8 and 9 respectively; count=2; each rsp_valid arrives 9 cycles after acceptance (DEPTH=8).
REQ-036 Write (5,8)=0xA5 over the existing key, then look up (5,8) -> write gives rsp_hit=1; count stays 2; lookup gives rdata=0xA5.
REQ-037 Look up (5,10), then (6,8) -> both give rsp_hit=0 and rdata=0, showing that partial key matches miss.
REQ-038 Fill 8 distinct keys, then write a 9th key, then look up the 9th key -> the 9th write gives rsp_err=1 and count=8; the lookup misses; a write to an existing key still succeeds.
REQ-039 Assert reset 3 cycles into the scan of a write, release it, then look up the same key -> no rsp_valid during the aborted scan; the lookup misses; count=0.
REQ-040 Hold req_valid high continuously with 4 queued requests -> exactly one acceptance per 10 cycles; no request is lost or accepted twice.
